// File: rtl/vpu_mem_pkg.sv
// Shared types for the vector memory path (load and store engines).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vpu_mem_pkg;

  // Output buffer depth. Two entries, together with at most one read in
  // flight, are enough to sustain one element per cycle through a 1-cycle bram.
  localparam int VLOAD_FIFO_DEPTH = 2;
  localparam int VLOAD_CNT_W      = $clog2(VLOAD_FIFO_DEPTH + 1);
  localparam int VLOAD_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } vload_state_e;

  // One buffered element: the bram word plus its end-of-command tag.
  typedef struct packed {
    logic [VLOAD_DATA_WIDTH-1:0] data;
    logic                        last;
  } vload_elem_t;

endpackage

// File: rtl/stream_fifo2.sv
// 2-entry synchronous FIFO with a registered head entry.
// Latency: a push becomes visible at head_o in the following cycle.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports: clk/rst_n; push_i + din_i write; pop_i removes head; head_o current head;
//        count_o occupancy (0..2).
module stream_fifo2
  import vpu_mem_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [VLOAD_CNT_W-1:0] count_o
);

  localparam logic [VLOAD_CNT_W-1:0] FULL = VLOAD_CNT_W'(VLOAD_FIFO_DEPTH);

  logic [WIDTH-1:0]       head_q, head_d;
  logic [WIDTH-1:0]       tail_q, tail_d;
  logic [VLOAD_CNT_W-1:0] cnt_q, cnt_d;
  logic                   do_pop, do_push;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != FULL) || do_pop);

  // Entries shift toward the head so the output is always a plain register.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == '0) head_d = din_i;
        else             tail_d = din_i;
        cnt_d = cnt_q + 1'b1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 1'b1;
      end
      2'b11: begin
        if (cnt_q == VLOAD_CNT_W'(1)) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/vec_load_unit.sv
// Strided vector load: reads length words at base + i*stride from one bram port
// and streams them out. Latency: start at edge 0 -> first read cycle 1 -> m_valid cycle 3.
// Backpressure: reads are throttled so buffered + in-flight elements never exceed 2.
// Ports: start/base_addr/stride/length command (sampled in IDLE); busy/done status;
//        bram_en/bram_we/bram_addr/bram_din/bram_dout read port; m_valid/m_ready/m_data/m_last stream.
module vec_load_unit
  import vpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = VLOAD_DATA_WIDTH,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } elem_t;

  localparam int PW = VLOAD_CNT_W + 1;

  vload_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  inflight_q, inflight_d;
  logic                  infl_last_q, infl_last_d;
  logic                  done_q, done_d;

  logic                   issue;
  logic                   pop;
  logic [VLOAD_CNT_W-1:0] fifo_cnt;
  logic [PW-1:0]          pending;
  elem_t                  push_elem;
  elem_t                  head_elem;

  assign pop     = m_valid && m_ready;
  assign pending = {1'b0, fifo_cnt} + PW'(inflight_q);

  // A read may go out when a slot is free now, or when the only full slot
  // is being vacated by a downstream accept this same cycle.
  assign issue = (state_q == ISSUE) &&
                 ((pending < PW'(VLOAD_FIFO_DEPTH)) ||
                  ((pending == PW'(VLOAD_FIFO_DEPTH)) && pop));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    remain_d    = remain_q;
    done_d      = 1'b0;
    inflight_d  = issue;
    // The last tag rides with the read so it lands in the FIFO with its data.
    infl_last_d = issue && (remain_q == LEN_WIDTH'(1));
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d  = ISSUE;
            addr_d   = base_addr;
            stride_d = stride;
            remain_d = length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d   = addr_q + stride_q;
          remain_d = remain_q - 1'b1;
          if (remain_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_elem.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      remain_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      remain_q    <= remain_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  // bram_dout is valid the cycle after the read; capture it then.
  assign push_elem = '{data: bram_dout, last: infl_last_q};

  stream_fifo2 #(
    .WIDTH($bits(elem_t))
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (inflight_q),
    .din_i  (push_elem),
    .pop_i  (pop),
    .head_o (head_elem),
    .count_o(fifo_cnt)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign bram_en   = issue;
  assign bram_we   = 1'b0;
  assign bram_addr = addr_q;
  assign bram_din  = '0;
  assign m_valid   = (fifo_cnt != '0);
  assign m_data    = head_elem.data;
  assign m_last    = head_elem.last;

endmodule

// File: tb/tb_vec_load_unit.sv
module tb_vec_load_unit;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LW    = 11;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] stride;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  always #5 clk = ~clk;

  vec_load_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .stride   (stride),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .bram_en  (bram_en),
    .bram_we  (bram_we),
    .bram_addr(bram_addr),
    .bram_din (bram_din),
    .bram_dout(bram_dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  // Behavioural bram: registered read, one cycle latency.
  logic [DW-1:0] mem [MEMSZ];
  always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] addr_log[$];

  int n_cmp = 0;
  int n_bad = 0;
  int issued = 0;
  int popped = 0;
  int done_seen = 0;
  int ready_mode = 0;

  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  function automatic void fail_now(input string name, input string detail);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, detail);
  endfunction

  // Reference: element i of a command reads (base + i*stride) mod 2^AW.
  function automatic void model_cmd(input int b, input int s, input int n);
    for (int i = 0; i < n; i++) begin
      int    a;
      beat_t e;
      a      = (b + i * s) % MEMSZ;
      e.data = mem[a];
      e.last = (i == n - 1);
      exp_addr_q.push_back(AW'(a));
      exp_q.push_back(e);
    end
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    beat_t got;
    if (!rst_n) begin
      stall_prev = 1'b0;
      exp_q.delete();
      exp_addr_q.delete();
      issued = 0;
      popped = 0;
    end else begin
      if (bram_en) begin
        check("issue_while_full", 64'(((issued - popped) >= 2) && !(m_valid && m_ready)), 64'(0));
        check("bram_we", 64'(bram_we), 64'(0));
        check("bram_din", 64'(bram_din), 64'(0));
        if (exp_addr_q.size() == 0)
          fail_now("unexpected_issue", $sformatf("bram_en with addr %0d, required no read", bram_addr));
        else
          check("bram_addr", 64'(bram_addr), 64'(exp_addr_q.pop_front()));
        addr_log.push_back(bram_addr);
        issued++;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat", $sformatf("data 0x%0h accepted, required none", m_data));
        end else begin
          got = exp_q.pop_front();
          check("beat_data", 64'(m_data), 64'(got.data));
          check("beat_last", 64'(m_last), 64'(got.last));
        end
        popped++;
      end
      if (stall_prev) begin
        check("stall_valid", 64'(m_valid), 64'(1));
        check("stall_data", 64'(m_data), 64'(prev_data));
        check("stall_last", 64'(m_last), 64'(prev_last));
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) done_seen++;
    end
  end

  // Downstream ready: 0 = always, 1 = fixed pattern, 2 = random.
  bit pat [6] = '{1, 0, 0, 1, 0, 1};
  int pat_idx = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: begin
          m_ready = pat[pat_idx];
          pat_idx = (pat_idx + 1) % 6;
        end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic issue_cmd(input int b, input int s, input int n, input bit model);
    start     = 1'b1;
    base_addr = AW'(b);
    stride    = AW'(s);
    length    = LW'(n);
    if (model) model_cmd(b, s, n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (done !== 1'b1 && c < budget);
    check({name, "_done"}, 64'(done), 64'(1));
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_done"}, 64'(done), 64'(0));
    check({name, "_bram_en"}, 64'(bram_en), 64'(0));
    check({name, "_bram_addr"}, 64'(bram_addr), 64'(0));
    check({name, "_m_valid"}, 64'(m_valid), 64'(0));
    check({name, "_m_data"}, 64'(m_data), 64'(0));
    check({name, "_m_last"}, 64'(m_last), 64'(0));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int d0;
    int b;
    int s;
    int n;
    rst_n     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    stride    = '0;
    length    = '0;
    for (int i = 0; i < MEMSZ; i++) mem[i] = DW'(i * 3);

    #2 rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic load with exact cycle timing; edge 0 samples start.
    ready_mode = 0;
    issue_cmd(4, 1, 4, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("basic_busy_c%0d", c), 64'(busy), 64'(c <= 6));
      check($sformatf("basic_done_c%0d", c), 64'(done), 64'(c == 7));
      check($sformatf("basic_en_c%0d", c), 64'(bram_en), 64'(c <= 4));
      check($sformatf("basic_valid_c%0d", c), 64'(m_valid), 64'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) begin
        check($sformatf("basic_data_c%0d", c), 64'(m_data), 64'(12 + 3 * (c - 3)));
        check($sformatf("basic_last_c%0d", c), 64'(m_last), 64'(c == 6));
      end
    end
    check("basic_drained", 64'(exp_q.size()), 64'(0));

    // Backpressure pattern.
    ready_mode = 1;
    p0 = popped;
    issue_cmd(4, 1, 4, 1'b1);
    wait_done("bp", 300);
    check("bp_beats", 64'(popped - p0), 64'(4));
    ready_mode = 0;

    // Stride with address wrap.
    for (int i = 0; i < MEMSZ; i++) mem[i] = $urandom;
    addr_log.delete();
    issue_cmd(1022, 3, 3, 1'b1);
    wait_done("wrap", 100);
    check("wrap_nreads", 64'(addr_log.size()), 64'(3));
    if (addr_log.size() == 3) begin
      check("wrap_addr0", 64'(addr_log[0]), 64'(1022));
      check("wrap_addr1", 64'(addr_log[1]), 64'(1));
      check("wrap_addr2", 64'(addr_log[2]), 64'(4));
    end

    // Zero length: done next cycle, never busy, no reads.
    issue_cmd(100, 1, 0, 1'b1);
    @(negedge clk);
    check("zero_done", 64'(done), 64'(1));
    check("zero_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("zero_done_once", 64'(done), 64'(0));
    check("zero_busy_after", 64'(busy), 64'(0));

    // Start while busy is ignored.
    p0 = popped;
    issue_cmd(10, 2, 4, 1'b1);
    @(negedge clk);
    issue_cmd(500, 7, 9, 1'b0);
    wait_done("ign", 100);
    repeat (4) @(negedge clk);
    check("ign_beats", 64'(popped - p0), 64'(4));
    check("ign_idle", 64'(busy), 64'(0));

    // Reset mid-command.
    p0 = popped;
    issue_cmd(200, 1, 10, 1'b1);
    for (int c = 0; c < 50 && (popped - p0) < 2; c++) @(negedge clk);
    check("abort_two_beats", 64'(popped - p0), 64'(2));
    d0 = done_seen;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", 64'(done_seen), 64'(d0));
    check("abort_idle", 64'(busy), 64'(0));
    issue_cmd(300, 5, 5, 1'b1);
    wait_done("fresh", 100);

    // Randomized commands.
    for (int k = 0; k < 40; k++) begin
      ready_mode = $urandom_range(0, 2);
      if ((k % 10) == 0) for (int i = 0; i < MEMSZ; i++) mem[i] = $urandom;
      b = $urandom_range(0, MEMSZ - 1);
      s = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, MEMSZ - 1);
      n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
      issue_cmd(b, s, n, 1'b1);
      wait_done($sformatf("rand%0d", k), 400);
    end
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check("final_drained", 64'(exp_q.size()), 64'(0));
    check("final_addr_drained", 64'(exp_addr_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
